// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: synchronise, debounce, qualify edges by mode,
// and stretch each qualifying edge into a retriggerable pulse of PULSE_LEN cycles.
module edge_pulse_gen #(
    parameter int CH              = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int PULSE_LEN       = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CH-1:0]     in,
    input  logic [2*CH-1:0]   mode,
    output logic [CH-1:0]     out,
    output logic [CH-1:0]     level,
    output logic              any_out
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    logic [CH-1:0] out_d;
    logic [CH-1:0] out_q;
    logic          any_out_q;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   level_q, level_d;
        logic [DW-1:0]          dcnt_q, dcnt_d;
        logic [PW-1:0]          pcnt_q, pcnt_d;
        logic                   s;
        logic                   accept;
        logic                   qual;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            level_d = level_q;
            dcnt_d  = dcnt_q;
            accept  = 1'b0;
            if (s == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = s;
                dcnt_d  = '0;
                accept  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        // After an accepted transition the new level equals s, so s gives the edge direction.
        assign qual = accept && ((s && mode[2*g]) || (!s && mode[2*g+1]));

        always_comb begin
            pcnt_d = pcnt_q;
            if (qual) begin
                pcnt_d = PW'(PULSE_LEN);
            end else if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - PW'(1);
            end
        end

        assign out_d[g] = (pcnt_d != '0);
        assign level[g] = level_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q  <= '0;
                level_q <= 1'b0;
                dcnt_q  <= '0;
                pcnt_q  <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], in[g]};
                level_q <= level_d;
                dcnt_q  <= dcnt_d;
                pcnt_q  <= pcnt_d;
            end
        end
    end

    // any_out is built from next-state values so it tracks out in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q     <= '0;
            any_out_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            any_out_q <= |out_d;
        end
    end

    assign out     = out_q;
    assign any_out = any_out_q;

endmodule
